// File: rtl/input_number_pkg.sv
// input_number_pkg: shared FSM states, default sizes and the sum-width helper for the accumulator.
package input_number_pkg;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_NUM_COUNT = 4;
    typedef enum logic [1:0] {IDLE, COLLECT, SHIFT, DONE} state_t;
    function automatic int sum_width(input int data_w, input int num_count);
        return data_w + $clog2(num_count);
    endfunction
endpackage

// File: rtl/sum_piso_shifter.sv
// sum_piso_shifter: parallel-load, shift-left-by-one register exposing its MSB.
module sum_piso_shifter #(
    parameter int SUM_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [SUM_W-1:0] din,
    output logic             msb
);
    logic [SUM_W-1:0] q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q <= '0;
        else if (load) q <= din;
        else if (shift) q <= {q[SUM_W-2:0], 1'b0};
    end
    assign msb = q[SUM_W-1];
endmodule

// File: rtl/input_number_accumulator.sv
// input_number_accumulator: sums NUM_COUNT received numbers and shifts the sum out MSB first.
module input_number_accumulator
    import input_number_pkg::*;
#(
    parameter int NUM_COUNT = DEF_NUM_COUNT,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              num_valid,
    input  logic [DATA_W-1:0] num_in,
    output logic              busy,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              done,
    output logic              drop
);
    localparam int SUM_W = sum_width(DATA_W, NUM_COUNT);
    localparam int CNT_W = $clog2(NUM_COUNT);
    localparam int BIT_W = $clog2(SUM_W);
    state_t state, state_nx;
    logic [SUM_W-1:0] sum, sum_add;
    logic [CNT_W-1:0] num_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic last_num, last_bit, load, msb;
    assign sum_add  = sum + SUM_W'(num_in);
    assign last_num = num_valid && num_cnt == CNT_W'(NUM_COUNT - 1);
    assign last_bit = bit_cnt == BIT_W'(SUM_W - 1);
    assign load     = state == COLLECT && last_num;
    always_comb begin
        state_nx  = state;
        busy      = state != IDLE;
        ser_valid = state == SHIFT;
        ser_out   = state == SHIFT && msb;
        done      = state == DONE;
        case (state)
            IDLE:    state_nx = start ? COLLECT : IDLE;
            COLLECT: state_nx = last_num ? SHIFT : COLLECT;
            SHIFT:   state_nx = last_bit ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            sum     <= '0;
            num_cnt <= '0;
            bit_cnt <= '0;
            drop    <= 1'b0;
        end else begin
            state   <= state_nx;
            drop    <= num_valid && state != COLLECT;
            bit_cnt <= state == SHIFT ? bit_cnt + 1'b1 : '0;
            if (state == IDLE && start) begin
                sum     <= '0;
                num_cnt <= '0;
            end else if (state == COLLECT && num_valid) begin
                sum     <= sum_add;
                num_cnt <= num_cnt + 1'b1;
            end
        end
    end
    sum_piso_shifter #(.SUM_W(SUM_W)) u_shift (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .shift (state == SHIFT),
        .din   (sum_add),
        .msb   (msb)
    );
endmodule

// File: tb/tb_input_number_accumulator.sv
// tb_input_number_accumulator: table-driven runs plus hand sequences for reset, drop and overlap cases.
module tb_input_number_accumulator;
    logic clk = 1'b0;
    logic rst, start, num_valid;
    logic [7:0] num_in;
    logic busy, ser_out, ser_valid, done, drop;
    int total = 0;
    int bad = 0;
    typedef struct {
        logic [7:0] n [4];
        int         gap;
        bit         poke;
        logic [9:0] exp;
    } vec_t;
    vec_t tbl [7];
    input_number_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_valid (num_valid),
        .num_in    (num_in),
        .busy      (busy),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done),
        .drop      (drop)
    );
    always #5 clk = ~clk;
    task automatic chk1(input string name, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, exp);
        end
    endtask
    task automatic chkw(input string name, input logic [9:0] got, input logic [9:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, got, exp);
        end
    endtask
    task automatic step(input logic st, input logic nv, input logic [7:0] n);
        start = st;
        num_valid = nv;
        num_in = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        num_valid = 1'b0;
        num_in = 8'd0;
    endtask
    task automatic chk_quiet(input string name);
        chk1({name, "_busy"}, busy, 1'b0);
        chk1({name, "_ser_out"}, ser_out, 1'b0);
        chk1({name, "_ser_valid"}, ser_valid, 1'b0);
        chk1({name, "_done"}, done, 1'b0);
        chk1({name, "_drop"}, drop, 1'b0);
    endtask
    task automatic run_vec(input int idx, input bit with_start);
        logic [9:0] got;
        if (with_start) begin
            step(1'b1, 1'b0, 8'd0);
            chk1("busy_start", busy, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0)
                for (int g = 0; g < tbl[idx].gap; g++) begin
                    step(tbl[idx].poke, 1'b0, 8'd0);
                    chk1("busy_collect", busy, 1'b1);
                    chk1("ser_valid_collect", ser_valid, 1'b0);
                end
            step(1'b0, 1'b1, tbl[idx].n[i]);
        end
        got = '0;
        for (int b = 0; b < 10; b++) begin
            chk1("ser_valid", ser_valid, 1'b1);
            chk1("done_early", done, 1'b0);
            if (b > 0) chk1("drop_shift", drop, tbl[idx].poke);
            got = {got[8:0], ser_out};
            step(1'b0, tbl[idx].poke, 8'hFF);
        end
        chkw($sformatf("sum_%0d", idx), got, tbl[idx].exp);
        chk1("done", done, 1'b1);
        chk1("busy_done", busy, 1'b1);
        chk1("drop_last", drop, tbl[idx].poke);
        chk1("ser_valid_off", ser_valid, 1'b0);
        chk1("ser_out_off", ser_out, 1'b0);
        step(tbl[idx].poke, 1'b0, 8'd0);
        chk1("done_once", done, 1'b0);
        chk1("busy_idle", busy, 1'b0);
    endtask
    initial begin
        tbl[0] = '{n: '{8'd1, 8'd2, 8'd3, 8'd4},         gap: 2, poke: 1'b0, exp: 10'b0000001010};
        tbl[1] = '{n: '{8'd255, 8'd255, 8'd255, 8'd255}, gap: 0, poke: 1'b0, exp: 10'b1111111100};
        tbl[2] = '{n: '{8'd128, 8'd64, 8'd32, 8'd1},     gap: 0, poke: 1'b0, exp: 10'b0011100001};
        tbl[3] = '{n: '{8'd7, 8'd8, 8'd9, 8'd10},        gap: 1, poke: 1'b1, exp: 10'b0000100010};
        tbl[4] = '{n: '{8'd0, 8'd0, 8'd0, 8'd0},         gap: 0, poke: 1'b0, exp: 10'b0000000000};
        tbl[5] = '{n: '{8'd10, 8'd20, 8'd30, 8'd40},     gap: 0, poke: 1'b0, exp: 10'b0001100100};
        tbl[6] = '{n: '{8'd5, 8'd5, 8'd5, 8'd5},         gap: 0, poke: 1'b0, exp: 10'b0000010100};
        rst = 1'b0;
        start = 1'b0;
        num_valid = 1'b0;
        num_in = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        chk_quiet("idle");
        step(1'b0, 1'b1, 8'd77);
        chk1("drop_idle", drop, 1'b1);
        chk1("busy_idle_drop", busy, 1'b0);
        step(1'b0, 1'b0, 8'd0);
        chk1("drop_clear", drop, 1'b0);
        for (int i = 0; i < 5; i++) run_vec(i, 1'b1);
        step(1'b1, 1'b1, 8'd99);
        chk1("busy_simul", busy, 1'b1);
        chk1("drop_simul", drop, 1'b1);
        run_vec(5, 1'b0);
        step(1'b1, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'd200);
        repeat (3) step(1'b0, 1'b0, 8'd0);
        chk1("ser_valid_pre_rst", ser_valid, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        chk_quiet("async_rst_shift");
        @(posedge clk);
        #1;
        chk_quiet("held_rst_shift");
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 8'd0);
            chk1("no_done_after_rst", done, 1'b0);
            chk1("idle_after_rst", busy, 1'b0);
        end
        step(1'b1, 1'b0, 8'd0);
        step(1'b0, 1'b1, 8'd50);
        step(1'b0, 1'b1, 8'd60);
        #2;
        rst = 1'b0;
        #1;
        chk_quiet("async_rst_collect");
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b0, 1'b0, 8'd0);
        chk_quiet("after_rst_collect");
        run_vec(6, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/input_number_accumulator.md
# input_number_accumulator

Downstream consumer of the serial-input number receiver. It collects a fixed count of 8-bit parallel numbers, each announced by the receiver's carry-out pulse, and sums them exactly without overflow. It then shifts the sum out serially, MSB first, with a valid strobe. A one-cycle done pulse marks the end of the shift.

## Interface
- NUM_COUNT, 4: numbers summed per run; must be ≥2.
- DATA_W, 8: width of each input number.
- SUM_W (localparam): DATA_W + clog2(NUM_COUNT); 10 with defaults.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  asynchronous, active-low reset; asserting it (0) clears all state immediately.
- start  in  1  starts a run; sampled only in IDLE.
- num_valid  in  1  one-cycle strobe from the receiver's carry-out; num_in is valid this cycle.
- num_in  in  DATA_W  parallel number from the receiver.
- busy  out  1  high in COLLECT, SHIFT and DONE.
- ser_out  out  1  current sum bit; 0 outside SHIFT.
- ser_valid  out  1  high only during SHIFT.
- done  out  1  one-cycle pulse in DONE.
- drop  out  1  one-cycle pulse when num_valid arrives outside COLLECT.

## Operation
- FSM states: IDLE, COLLECT, SHIFT, DONE.
- IDLE:
  - start=1 → COLLECT; sum←0, num_cnt←0.
  - num_valid is ignored and pulses drop.
- COLLECT:
  - num_valid=1 → sum←sum+zero-extended num_in, num_cnt←num_cnt+1.
  - On the NUM_COUNT-th num_valid: shreg←sum+num_in, bit_cnt←0, → SHIFT.
  - start is ignored.
  - No timeout; the block waits indefinitely between numbers.
- SHIFT:
  - ser_out=shreg[SUM_W-1], ser_valid=1.
  - Each cycle: shreg shifts left by one, filling with 0; bit_cnt increments.
  - After bit SUM_W-1 → DONE.
  - num_valid pulses drop and is not stored.
- DONE: done=1 for one cycle, then → IDLE unconditionally. start in DONE is ignored.
- Arithmetic: unsigned; SUM_W bits never overflow; no saturation logic.
- num_valid and start together in IDLE: start is taken, num_valid is dropped (drop=1).
- Reset mid-run (any state): FSM goes to IDLE and all registers clear asynchronously. The partial sum is lost; no done pulse.

## Timing
- Reset values: busy=0, ser_out=0, ser_valid=0, done=0, drop=0; sum, shreg and counters = 0; state IDLE.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- start sampled at edge k → busy=1 from edge k.
- Each number is captured on the edge where num_valid=1. Back-to-back num_valid on consecutive cycles must be accepted.
- Last num_valid at edge k → ser_valid=1 and first bit (MSB) from edge k, held SUM_W cycles (edges k … k+SUM_W-1).
- done=1 for the cycle after edge k+SUM_W; IDLE after edge k+SUM_W+1.
- Minimum run with defaults: 1 (start) + 4 (numbers) + 10 (shift) + 1 (done) = 16 cycles.
- drop is registered: high the cycle after the ignored num_valid.

## Structure
- Shared package `input_number_pkg`:
  - state enum (IDLE, COLLECT, SHIFT, DONE);
  - clog2-based SUM_W helper function;
  - default DATA_W and NUM_COUNT constants.
- One sub-module, `sum_piso_shifter`: parameterised SUM_W parallel-load, shift-left register with load/shift enables and MSB output. The FSM, adder and counters stay in the top.

## Test plan
- Reset: hold rst=0 mid-SHIFT with random state → all outputs 0 at once. After release, state is IDLE and no done pulse appears.
- Basic sum: start, then numbers 1, 2, 3, 4 spaced 3 cycles apart → ser_out = 0000001010 over 10 cycles with ser_valid high; done pulses once.
- Max value: four × 255, back-to-back num_valid → sum 1020, ser_out = 1111111100; no overflow.
- Ignored inputs:
  - num_valid in IDLE and during SHIFT → drop pulses; serial result unchanged.
  - start during COLLECT → no effect.
- Simultaneous start+num_valid in IDLE → run starts, that number is not counted, drop=1. Next four numbers 10, 20, 30, 40 → sum 100 = 0001100100.
- Reset mid-COLLECT after two numbers, then a new run with 5, 5, 5, 5 → sum 20 = 0000010100; no residue from the aborted run.
